alu_acc_sequencer: RTL and testbench
====================================

Name: alu_acc_sequencer

Overview:
- Control sequencer that drives the accumulator/ALU datapath control lines and consumes its flags.
- Accepts one instruction at a time over a start/ready handshake.
- Expands each instruction into a fixed per-cycle sequence of acc select, ALU op and bus-read strobes, including multi-cycle shift-add multiply and shift-subtract divide.
- Latches the flags and pulses done when the instruction completes.

Parameters:
- DATA_W, 4, accumulator half width; also the number of MUL/DIV iterations.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset; one clock, sampled on rising edge of clk
- start  input  1  instruction request; accepted only when ready=1
- opcode  input  3  000 NOP, 001 LDA, 010 ADD, 011 SUB, 100 MUL, 101 DIV, 110 AND, 111 reserved (executes as NOP)
- zero_flag  input  1  datapath zero flag
- sign_flag  input  1  datapath sign flag
- ready  output  1  high in IDLE only
- done  output  1  one-cycle completion pulse
- flag_z  output  1  zero flag latched at completion
- flag_s  output  1  sign flag latched at completion
- acc_high_reset_p  output  1  clears acc high half
- rd_en  output  1  bus read strobe into acc
- acc_in_select  output  1  0 = bus, 1 = ALU
- acc_high_select_in  output  2  00 hold, 01 shift right, 10 shift left, 11 load
- acc_low_select  output  2  same encoding as acc_high_select_in
- op_add, op_sub, op_mul, op_div, op_and  output  1 each  ALU op strobes, one-hot or all zero

Behaviour:
- States: IDLE, LOAD, EXEC, SETUP, MUL_ADD, MUL_SHIFT, DIV_SHIFT, DIV_SUB, DIV_FIX, DONE.
- Iteration counter: clog2(DATA_W) bits.
- All datapath controls are decoded from the registered state, opcode register and counter. Controls are all zero in IDLE and DONE.
- Handshake:
  - start & ready at edge N latches opcode and leaves IDLE.
  - The first control cycle is cycle N+1.
  - start while ready=0 is ignored; opcode is not re-sampled.
- Per-opcode sequences:
  - NOP/reserved: IDLE -> DONE. done rises at N+1, no controls asserted.
  - LDA: LOAD for 1 cycle with rd_en=1, acc_in_select=0, acc_low_select=11, acc_high_reset_p=1. Then DONE.
  - ADD/SUB/AND: EXEC for 1 cycle with the matching op strobe, acc_in_select=1, acc_high_select_in=11. Then DONE.
  - MUL: SETUP (acc_high_reset_p=1), then DATA_W x [MUL_ADD, MUL_SHIFT], then DONE.
    - MUL_ADD: op_mul=1, acc_in_select=1, acc_high_select_in=11. The datapath gates the high load on the acc low LSB.
    - MUL_SHIFT: high=01, low=01.
  - DIV: SETUP (acc_high_reset_p=1), then DATA_W x [DIV_SHIFT, DIV_SUB], then DIV_FIX, then DONE.
    - DIV_SHIFT: high=10, low=10.
    - DIV_SUB: op_div=1, acc_in_select=1, acc_high_select_in=11. The datapath gates the load on cout.
    - DIV_FIX: low=10 only, shifting in the final quotient bit.
- Counter:
  - Cleared in SETUP.
  - Increments on MUL_SHIFT / DIV_SUB.
  - Loop exits when the counter = DATA_W-1 at that state.
- Control-cycle counts: NOP 0, LDA 1, ADD/SUB/AND 1, MUL 1+2*DATA_W (9), DIV 2+2*DATA_W (10).
- DONE state (1 cycle):
  - done=1.
  - flag_z/flag_s load zero_flag/sign_flag.
  - Next state IDLE; ready=1 the following cycle.
  - A start coincident with done is ignored.
- Flags hold their value between completions.
- Reset (reset_n=0 at an edge), at any point including mid-MUL/DIV:
  - State goes to IDLE and the counter clears.
  - flag_z=0, flag_s=0, done=0, ready=1, all controls 0 from the next cycle.
  - No partial sequence resumes.
- Reset values: ready=1; all other outputs 0.
- At most one op_* strobe is high in any cycle.
- acc_high_select_in and acc_low_select never take 11 in the same cycle except in LDA (low) and EXEC/MUL_ADD/DIV_SUB (high only).

Test Plan:
- Reset then LDA: start=1, opcode=001 -> cycle N+1: rd_en=1, acc_low_select=11, acc_high_reset_p=1; N+2: done=1; N+3: ready=1.
- ADD with zero_flag=1, sign_flag=0 at DONE -> EXEC cycle op_add=1, acc_in_select=1, acc_high_select_in=11; done one cycle later; flag_z=1, flag_s=0 held until the next done.
- MUL (DATA_W=4) -> 9 control cycles, exactly 4 op_mul pulses alternating with 4 shift-right cycles (01/01); done at N+10. A start=1 asserted during the sequence produces no effect.
- DIV (DATA_W=4) -> SETUP, 4x(shift-left 10/10, op_div), DIV_FIX low=10 high=00; done at N+11.
- Reset mid-MUL: drive reset_n=0 at the 3rd MUL_ADD -> next cycle all controls 0, ready=1, flags 0. A subsequent ADD completes normally in 2 cycles.
- NOP and opcode 111 -> no control asserted, done at N+1. Back-to-back start on the first ready cycle is accepted.

Source files
------------

// File: rtl/alu_acc_sequencer.sv
// Control sequencer for the accumulator/ALU datapath.
// Expands one opcode into per-cycle control strobes and latches flags.
module alu_acc_sequencer #(
  parameter int DATA_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       zero_flag,
  input  logic       sign_flag,
  output logic       ready,
  output logic       done,
  output logic       flag_z,
  output logic       flag_s,
  output logic       acc_high_reset_p,
  output logic       rd_en,
  output logic       acc_in_select,
  output logic [1:0] acc_high_select_in,
  output logic [1:0] acc_low_select,
  output logic       op_add,
  output logic       op_sub,
  output logic       op_mul,
  output logic       op_div,
  output logic       op_and
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_EXEC      = 4'd2;
  localparam logic [3:0] S_SETUP     = 4'd3;
  localparam logic [3:0] S_MUL_ADD   = 4'd4;
  localparam logic [3:0] S_MUL_SHIFT = 4'd5;
  localparam logic [3:0] S_DIV_SHIFT = 4'd6;
  localparam logic [3:0] S_DIV_SUB   = 4'd7;
  localparam logic [3:0] S_DIV_FIX   = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  logic [3:0]    state_q, state_d;
  logic [2:0]    opc_q, opc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fz_q, fz_d;
  logic          fs_q, fs_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      opc_q   <= 3'b000;
      cnt_q   <= '0;
      fz_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      fz_q    <= fz_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q;
    fz_d    = fz_q;
    fs_d    = fs_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opc_d = opcode;
          case (opcode)
            OP_LDA:                 state_d = S_LOAD;
            OP_ADD, OP_SUB, OP_AND: state_d = S_EXEC;
            OP_MUL, OP_DIV:         state_d = S_SETUP;
            default:                state_d = S_DONE;
          endcase
        end
      end
      S_LOAD, S_EXEC: state_d = S_DONE;
      S_SETUP: begin
        cnt_d   = '0;
        state_d = (opc_q == OP_MUL) ? S_MUL_ADD : S_DIV_SHIFT;
      end
      S_MUL_ADD: state_d = S_MUL_SHIFT;
      S_MUL_SHIFT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? S_DONE : S_MUL_ADD;
      end
      S_DIV_SHIFT: state_d = S_DIV_SUB;
      S_DIV_SUB: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? S_DIV_FIX : S_DIV_SHIFT;
      end
      S_DIV_FIX: state_d = S_DONE;
      S_DONE: begin
        fz_d    = zero_flag;
        fs_d    = sign_flag;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_high_reset_p   = 1'b0;
    rd_en              = 1'b0;
    acc_in_select      = 1'b0;
    acc_high_select_in = SEL_HOLD;
    acc_low_select     = SEL_HOLD;
    op_add             = 1'b0;
    op_sub             = 1'b0;
    op_mul             = 1'b0;
    op_div             = 1'b0;
    op_and             = 1'b0;
    case (state_q)
      S_LOAD: begin
        rd_en            = 1'b1;
        acc_low_select   = SEL_LOAD;
        acc_high_reset_p = 1'b1;
      end
      S_EXEC: begin
        acc_in_select      = 1'b1;
        acc_high_select_in = SEL_LOAD;
        op_add             = (opc_q == OP_ADD);
        op_sub             = (opc_q == OP_SUB);
        op_and             = (opc_q == OP_AND);
      end
      S_SETUP: acc_high_reset_p = 1'b1;
      S_MUL_ADD: begin
        op_mul             = 1'b1;
        acc_in_select      = 1'b1;
        acc_high_select_in = SEL_LOAD;
      end
      S_MUL_SHIFT: begin
        acc_high_select_in = SEL_SHR;
        acc_low_select     = SEL_SHR;
      end
      S_DIV_SHIFT: begin
        acc_high_select_in = SEL_SHL;
        acc_low_select     = SEL_SHL;
      end
      S_DIV_SUB: begin
        op_div             = 1'b1;
        acc_in_select      = 1'b1;
        acc_high_select_in = SEL_LOAD;
      end
      // last quotient bit enters low half; high keeps the remainder
      S_DIV_FIX: acc_low_select = SEL_SHL;
      default: ;
    endcase
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = (state_q == S_DONE);
  assign flag_z = fz_q;
  assign flag_s = fs_q;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer: random opcode traffic checked
// against a per-opcode expected control schedule.
module tb_alu_acc_sequencer;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero_flag = 1'b0;
  logic       sign_flag = 1'b0;
  logic       ready, done, flag_z, flag_s;
  logic       acc_high_reset_p, rd_en, acc_in_select;
  logic [1:0] acc_high_select_in, acc_low_select;
  logic       op_add, op_sub, op_mul, op_div, op_and;

  int n_checks = 0;
  int n_fail = 0;
  logic held_z = 1'b0;
  logic held_s = 1'b0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  alu_acc_sequencer #(.DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .zero_flag(zero_flag), .sign_flag(sign_flag),
    .ready(ready), .done(done), .flag_z(flag_z), .flag_s(flag_s),
    .acc_high_reset_p(acc_high_reset_p), .rd_en(rd_en),
    .acc_in_select(acc_in_select),
    .acc_high_select_in(acc_high_select_in),
    .acc_low_select(acc_low_select),
    .op_add(op_add), .op_sub(op_sub), .op_mul(op_mul),
    .op_div(op_div), .op_and(op_and)
  );

  // {hrst, rd, insel, hi, lo, add, sub, mul, div, and}
  wire [11:0] ctrl = {acc_high_reset_p, rd_en, acc_in_select,
                      acc_high_select_in, acc_low_select,
                      op_add, op_sub, op_mul, op_div, op_and};

  function automatic logic [11:0] mk(logic hr, logic rd, logic ins,
                                     logic [1:0] hi, logic [1:0] lo,
                                     logic [4:0] ops);
    return {hr, rd, ins, hi, lo, ops};
  endfunction

  // Expected per-cycle controls, straight from the opcode descriptions
  task automatic build_exp(input logic [2:0] op);
    exp_q.delete();
    case (op)
      3'b001: exp_q.push_back(mk(1, 1, 0, 2'b00, 2'b11, 5'b00000));
      3'b010: exp_q.push_back(mk(0, 0, 1, 2'b11, 2'b00, 5'b10000));
      3'b011: exp_q.push_back(mk(0, 0, 1, 2'b11, 2'b00, 5'b01000));
      3'b110: exp_q.push_back(mk(0, 0, 1, 2'b11, 2'b00, 5'b00001));
      3'b100: begin
        exp_q.push_back(mk(1, 0, 0, 2'b00, 2'b00, 5'b00000));
        for (int i = 0; i < DW; i++) begin
          exp_q.push_back(mk(0, 0, 1, 2'b11, 2'b00, 5'b00100));
          exp_q.push_back(mk(0, 0, 0, 2'b01, 2'b01, 5'b00000));
        end
      end
      3'b101: begin
        exp_q.push_back(mk(1, 0, 0, 2'b00, 2'b00, 5'b00000));
        for (int i = 0; i < DW; i++) begin
          exp_q.push_back(mk(0, 0, 0, 2'b10, 2'b10, 5'b00000));
          exp_q.push_back(mk(0, 0, 1, 2'b11, 2'b00, 5'b00010));
        end
        exp_q.push_back(mk(0, 0, 0, 2'b00, 2'b10, 5'b00000));
      end
      default: ;
    endcase
  endtask

  // Called at a negedge on which the DUT should be ready; returns at the
  // negedge of the following ready cycle, so consecutive calls are b2b.
  task automatic exec_op(input logic [2:0] op, input logic zf,
                         input logic sf, output int n_mul);
    build_exp(op);
    n_mul = 0;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before op=%0d got=%b want=1", op, ready);
    end
    start  = 1'b1;
    opcode = op;
    foreach (exp_q[i]) begin
      @(negedge clk);
      n_checks++;
      if (ctrl !== exp_q[i] || ready !== 1'b0 || done !== 1'b0 ||
          flag_z !== held_z || flag_s !== held_s) begin
        n_fail++;
        $display("FAIL seq op=%0d cyc=%0d ctrl=%h want=%h rdy=%b dn=%b fz=%b fs=%b want fz=%b fs=%b",
                 op, i + 1, ctrl, exp_q[i], ready, done,
                 flag_z, flag_s, held_z, held_s);
      end
      if (op_mul === 1'b1) n_mul++;
      start     = $urandom_range(0, 1);
      opcode    = 3'($urandom);
      zero_flag = $urandom_range(0, 1);
      sign_flag = $urandom_range(0, 1);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || ctrl !== 12'h000 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle op=%0d done=%b ctrl=%h ready=%b want 1/000/0",
               op, done, ctrl, ready);
    end
    zero_flag = zf;
    sign_flag = sf;
    start     = 1'b1;
    opcode    = 3'($urandom);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || ctrl !== 12'h000 ||
        flag_z !== zf || flag_s !== sf) begin
      n_fail++;
      $display("FAIL after_done op=%0d done=%b ready=%b ctrl=%h fz=%b fs=%b want fz=%b fs=%b",
               op, done, ready, ctrl, flag_z, flag_s, zf, sf);
    end
    held_z    = zf;
    held_s    = sf;
    start     = 1'b0;
    zero_flag = $urandom_range(0, 1);
    sign_flag = $urandom_range(0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start   = 1'b1;
    opcode  = 3'b100;
    repeat (2) @(negedge clk);
    start   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || ctrl !== 12'h000 ||
        flag_z !== 1'b0 || flag_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ready=%b done=%b ctrl=%h fz=%b fs=%b", ready,
               done, ctrl, flag_z, flag_s);
    end
    held_z = 1'b0;
    held_s = 1'b0;
  endtask

  task automatic test_lda;
    int m;
    exec_op(3'b001, 1'b0, 1'b1, m);
  endtask

  task automatic test_add_flags;
    int m;
    idle(1);
    exec_op(3'b010, 1'b1, 1'b0, m);
    idle(3);
    n_checks++;
    if (flag_z !== 1'b1 || flag_s !== 1'b0) begin
      n_fail++;
      $display("FAIL flag_hold fz=%b fs=%b want 1 0", flag_z, flag_s);
    end
    exec_op(3'b011, 1'b0, 1'b1, m);
    exec_op(3'b110, 1'b1, 1'b1, m);
  endtask

  task automatic test_mul;
    int m;
    exec_op(3'b100, 1'b0, 1'b0, m);
    n_checks++;
    if (m != DW) begin
      n_fail++;
      $display("FAIL mul_pulses got=%0d want=%0d", m, DW);
    end
  endtask

  task automatic test_div;
    int m;
    idle(2);
    exec_op(3'b101, 1'b1, 1'b0, m);
  endtask

  task automatic test_reset_mid_mul;
    int adds;
    int m;
    adds = 0;
    exec_op(3'b010, 1'b1, 1'b1, m);
    start  = 1'b1;
    opcode = 3'b100;
    for (int i = 0; i < 20 && adds < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (op_mul === 1'b1) adds++;
    end
    n_checks++;
    if (adds != 3) begin
      n_fail++;
      $display("FAIL mid_mul_reach got=%0d want=3", adds);
    end
    reset_n = 1'b0;
    start   = 1'b1;
    opcode  = 3'b101;
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b0;
    n_checks++;
    if (ctrl !== 12'h000 || ready !== 1'b1 || done !== 1'b0 ||
        flag_z !== 1'b0 || flag_s !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_mul_reset ctrl=%h ready=%b done=%b fz=%b fs=%b",
               ctrl, ready, done, flag_z, flag_s);
    end
    held_z = 1'b0;
    held_s = 1'b0;
    idle(2);
    n_checks++;
    if (ready !== 1'b1 || ctrl !== 12'h000) begin
      n_fail++;
      $display("FAIL no_resume ready=%b ctrl=%h want 1 000", ready, ctrl);
    end
    exec_op(3'b010, 1'b0, 1'b1, m);
  endtask

  task automatic test_nop_reserved;
    int m;
    exec_op(3'b000, 1'b1, 1'b0, m);
    exec_op(3'b111, 1'b0, 1'b1, m);
  endtask

  task automatic test_back_to_back;
    int m;
    exec_op(3'b001, 1'b1, 1'b1, m);
    exec_op(3'b100, 1'b0, 1'b1, m);
    exec_op(3'b101, 1'b1, 1'b0, m);
    exec_op(3'b000, 1'b0, 1'b0, m);
  endtask

  task automatic test_random;
    int m;
    for (int k = 0; k < 60; k++) begin
      idle($urandom_range(0, 2));
      exec_op(3'($urandom), 1'($urandom), 1'($urandom), m);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lda();
    test_add_flags();
    test_mul();
    test_div();
    test_reset_mid_mul();
    test_nop_reserved();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
